riscv_run_monitor: RTL and testbench
====================================

# riscv_run_monitor

Synthesizable run-control and trace monitor for the single-cycle RISC-V core. It sits beside the core, watches the architectural `pc` and the data-memory write port, and counts cycles. It ends a run on a halt-PC match, a PC stall or a cycle timeout. Stores seen during the run are buffered in a first-word-fall-through trace FIFO for a bench or debug host to drain.

## Interface
Parameters:
- `XLEN`, 32, width of pc, address and data.
- `CNT_W`, 32, width of cycle and store counters.
- `MAX_CYCLES`, 1000, timeout limit in cycles; 0 disables timeout.
- `STALL_LIMIT`, 16, number of consecutive cycles with unchanged pc that counts as a stall; 0 disables.
- `TRACE_DEPTH`, 8, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset; **asynchronous, active-low**.
- `start`  in  1  one-cycle pulse that begins a run.
- `halt_pc`  in  XLEN  address of the last instruction.
- `pc`  in  XLEN  core program counter.
- `memWrite`  in  1  core store strobe.
- `aluO`  in  XLEN  store address.
- `writeData`  in  XLEN  store data.
- `running`  out  1  high in RUN.
- `done`  out  1  sticky end-of-run flag.
- `status`  out  2  00 none, 01 halt, 10 timeout, 11 stall.
- `cycle_count`  out  CNT_W  cycles spent in RUN.
- `store_count`  out  CNT_W  stores observed in RUN.
- `trace_valid`  out  1  FIFO non-empty.
- `trace_addr`  out  XLEN  head-entry address.
- `trace_data`  out  XLEN  head-entry data.
- `trace_rd`  in  1  pop the head entry; ignored when empty.
- `trace_ovf`  out  1  sticky flag: a store was dropped because the FIFO was full.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- IDLE, or DONE, with `start`=1 goes to RUN. On that transition:
  - clear the counters, `status`, `done`, `trace_ovf` and the stall counter;
  - empty the FIFO.
- In RUN, every cycle:
  - `cycle_count` increments and saturates at all-ones;
  - if `memWrite`=1, push `{aluO, writeData}` and increment `store_count` (saturating).
- The stall counter increments when `pc` equals the `pc` registered the previous cycle, and clears otherwise.
- End conditions are evaluated on the registered view of the same cycle, with priority halt > stall > timeout:
  - halt: `pc == halt_pc`;
  - stall: the stall counter reaches `STALL_LIMIT`-1 while `pc` is still unchanged;
  - timeout: `cycle_count` reaches `MAX_CYCLES`-1.
- On an end condition: go to DONE, set `done`=1 and latch `status`.
- The cycle in which the end condition is detected is counted, and its store is still pushed.
- DONE holds all counters and `status`. `start` in DONE restarts the run. `start` in RUN is ignored.
- FIFO behaviour:
  - full and push without pop: the entry is dropped, `trace_ovf` is set and `store_count` still increments;
  - full with simultaneous push and pop: both are accepted and the count is unchanged;
  - empty with simultaneous push and pop: the pop is ignored and the push is accepted.
- The FIFO is readable in every state.
- Pointers wrap modulo `TRACE_DEPTH`; an extra MSB distinguishes full from empty.
- Reset mid-run: immediately returns to IDLE and clears everything. No partial state survives.

## Timing
- Reset values:
  - `running`=0, `done`=0, `status`=00;
  - both counts 0;
  - `trace_valid`=0, `trace_ovf`=0;
  - `trace_addr`/`trace_data` = 0.
- `start` at edge N: `running`=1 after edge N, and the first counted cycle is the one ending at edge N+1.
- Halt match sampled at edge M: `done`=1, `running`=0 and `status` valid after edge M. Latency is one edge.
- FIFO is first-word-fall-through. A push at edge K gives `trace_valid`=1 with that data after edge K.
- A pop at edge K presents the next entry after edge K.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

## Test plan
- Halt: `halt_pc`=0x30, pc steps 0,4,…,0x30 at one instruction per cycle, `start` at cycle 0 -> `done`=1, `status`=01, `cycle_count`=13.
- Timeout: `MAX_CYCLES`=20, pc keeps advancing and never matches -> `status`=10, `cycle_count`=20, `running` drops after the 20th counted edge.
- Stall: `STALL_LIMIT`=4, pc held at 0x1C -> `status`=11 on the cycle with the fourth consecutive unchanged sample. Repeat with `halt_pc`=0x1C -> `status`=01, because halt wins over stall.
- Trace: `TRACE_DEPTH`=8, ten stores with `trace_rd`=0 -> 8 entries kept in order, `trace_ovf`=1, `store_count`=10.
  - Next, full FIFO with simultaneous push and pop -> the oldest entry leaves, the new one enters and `trace_valid` stays 1.
  - Then drain -> after the 8 reads `trace_valid`=0.
- Reset mid-run: deassert `rstn` asynchronously while `cycle_count`=5 and the FIFO holds 3 entries -> all outputs read zero before the next clock edge. A later `start` counts from 0.
- Restart: `start` in DONE -> counters, `status` and FIFO cleared, `running`=1 after the next edge.

Source files
------------

// File: rtl/riscv_run_monitor.sv
// Run-control and trace monitor for the single-cycle RISC-V core.
// Watches pc and the data-memory write port, counts cycles in RUN and ends
// the run on a halt-PC match, a PC stall or a cycle timeout (halt > stall >
// timeout). Stores seen in RUN go into a first-word-fall-through trace FIFO.
//
// Ports:
//   clk, rstn                  clock, async active-low reset
//   start                      one-cycle pulse, begins a run from IDLE/DONE
//   halt_pc, pc                halt address, core program counter
//   memWrite, aluO, writeData  core store strobe, address, data
//   running, done, status      run state, sticky end flag, end cause
//   cycle_count, store_count   saturating cycle / store counters
//   trace_valid/addr/data      FIFO head (non-empty flag, address, data)
//   trace_rd                   pop the FIFO head
//   trace_ovf                  sticky: a store was dropped on a full FIFO
module riscv_run_monitor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [XLEN-1:0]  halt_pc,
    input  logic [XLEN-1:0]  pc,
    input  logic             memWrite,
    input  logic [XLEN-1:0]  aluO,
    input  logic [XLEN-1:0]  writeData,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] store_count,
    output logic             trace_valid,
    output logic [XLEN-1:0]  trace_addr,
    output logic [XLEN-1:0]  trace_data,
    input  logic             trace_rd,
    output logic             trace_ovf
);

    localparam int unsigned AW    = $clog2(TRACE_DEPTH);
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned ENT_W = 2 * XLEN;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] STALL_LAST   = CNT_W'(STALL_LIMIT - 1);
    localparam bit               TIMEOUT_EN   = (MAX_CYCLES != 0);
    localparam bit               STALL_EN     = (STALL_LIMIT != 0);

    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_HALT    = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;
    localparam logic [1:0] STAT_STALL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              running_d, done_d;
    logic [1:0]        status_d;
    logic              start_run;
    logic              in_run;

    logic [XLEN-1:0]   pc_q;
    logic [CNT_W-1:0]  stall_q;
    logic              pc_same;
    logic              halt_hit, stall_hit, timeout_hit;

    logic [PW-1:0]     wr_q, rd_q;
    logic [ENT_W-1:0]  mem [TRACE_DEPTH];
    logic [ENT_W-1:0]  head;
    logic              fifo_empty, fifo_full;
    logic              push_req, push_ok, pop_ok;

    // End-condition detection on this cycle's pc and registered counters
    assign in_run      = (state_q == ST_RUN);
    assign pc_same     = (pc == pc_q);
    assign halt_hit    = (pc == halt_pc);
    assign stall_hit   = STALL_EN && pc_same && (stall_q == STALL_LAST);
    assign timeout_hit = TIMEOUT_EN && (cycle_count == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            status  <= STAT_NONE;
        end else begin
            state_q <= state_d;
            running <= running_d;
            done    <= done_d;
            status  <= status_d;
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        running_d = running;
        done_d    = done;
        status_d  = status;
        start_run = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                    status_d  = STAT_NONE;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_hit || stall_hit || timeout_hit) begin
                    state_d   = ST_DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    if (halt_hit)       status_d = STAT_HALT;
                    else if (stall_hit) status_d = STAT_STALL;
                    else                status_d = STAT_TIMEOUT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                running_d = 1'b0;
            end
        endcase
    end

    // Previous-cycle pc, free running so the first RUN cycle has a reference
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= '0;
        else       pc_q <= pc;
    end

    // Cycle, store and stall counters plus the sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_count <= '0;
            store_count <= '0;
            stall_q     <= '0;
            trace_ovf   <= 1'b0;
        end else if (start_run) begin
            cycle_count <= '0;
            store_count <= '0;
            stall_q     <= '0;
            trace_ovf   <= 1'b0;
        end else if (in_run) begin
            if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_W'(1);
            if (memWrite && (store_count != CNT_MAX)) store_count <= store_count + CNT_W'(1);
            if (!pc_same)                stall_q <= '0;
            else if (stall_q != CNT_MAX) stall_q <= stall_q + CNT_W'(1);
            if (push_req && !push_ok)    trace_ovf <= 1'b1;
        end
    end

    // Trace FIFO: extra pointer MSB separates full from empty
    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_req   = in_run && memWrite;
    assign pop_ok     = trace_rd && !fifo_empty && !start_run;
    assign push_ok    = push_req && (!fifo_full || pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (start_run) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop_ok)  rd_q <= rd_q + PW'(1);
        end
    end

    // Storage is reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(TRACE_DEPTH); i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_q[AW-1:0]] <= {aluO, writeData};
        end
    end

    assign head        = mem[rd_q[AW-1:0]];
    assign trace_valid = !fifo_empty;
    assign trace_addr  = head[ENT_W-1:XLEN];
    assign trace_data  = head[XLEN-1:0];

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Self-checking bench for riscv_run_monitor: halt, restart/timeout, stall,
// halt-over-stall priority, trace FIFO overflow/push-pop/drain, async reset.
module tb_riscv_run_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] halt_pc, pc, aluO, writeData;
    logic        memWrite, trace_rd;
    logic        running, done, trace_valid, trace_ovf;
    logic [1:0]  status;
    logic [31:0] cycle_count, store_count, trace_addr, trace_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    always #5 clk = ~clk;

    riscv_run_monitor #(
        .XLEN(32), .CNT_W(32), .MAX_CYCLES(20), .STALL_LIMIT(4), .TRACE_DEPTH(8)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .halt_pc(halt_pc), .pc(pc),
        .memWrite(memWrite), .aluO(aluO), .writeData(writeData),
        .running(running), .done(done), .status(status),
        .cycle_count(cycle_count), .store_count(store_count),
        .trace_valid(trace_valid), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_rd(trace_rd), .trace_ovf(trace_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; start = 0; halt_pc = 0; pc = 0; memWrite = 0;
        aluO = 0; writeData = 0; trace_rd = 0;
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (running !== 1'b0)     begin n_err++; $display("FAIL rst_running got=%0h exp=0", running); end
        n_cmp++; if (done !== 1'b0)        begin n_err++; $display("FAIL rst_done got=%0h exp=0", done); end
        n_cmp++; if (status !== 2'b00)     begin n_err++; $display("FAIL rst_status got=%0h exp=0", status); end
        n_cmp++; if (cycle_count !== 0)    begin n_err++; $display("FAIL rst_cycle got=%0h exp=0", cycle_count); end
        n_cmp++; if (store_count !== 0)    begin n_err++; $display("FAIL rst_store got=%0h exp=0", store_count); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got=%0h exp=0", trace_valid); end
        n_cmp++; if (trace_ovf !== 1'b0)   begin n_err++; $display("FAIL rst_ovf got=%0h exp=0", trace_ovf); end
        n_cmp++; if ({trace_addr, trace_data} !== 64'h0) begin n_err++; $display("FAIL rst_head got=%h_%h exp=0", trace_addr, trace_data); end
        @(negedge clk) rstn = 1'b1;
        tick();
        n_cmp++; if (running !== 1'b0)     begin n_err++; $display("FAIL idle_running got=%0h exp=0", running); end
    endtask

    task automatic test_halt();
        halt_pc = 32'h30; pc = 32'h100; start = 1;
        tick();
        start = 0;
        n_cmp++; if (running !== 1'b1)  begin n_err++; $display("FAIL halt_start_running got=%0h exp=1", running); end
        n_cmp++; if (cycle_count !== 0) begin n_err++; $display("FAIL halt_start_cycle got=%0d exp=0", cycle_count); end
        for (int i = 0; i < 13; i++) begin
            pc = 4 * i;
            memWrite = (i == 3 || i == 12);
            aluO = 32'h2000 + i;
            writeData = $urandom;
            if (memWrite) sb.push_back({aluO, writeData});
            tick();
            if (i == 11) begin
                n_cmp++; if (running !== 1'b1 || cycle_count !== 12) begin n_err++; $display("FAIL halt_mid got run=%0h cyc=%0d exp run=1 cyc=12", running, cycle_count); end
            end
        end
        memWrite = 0;
        n_cmp++; if (done !== 1'b1)     begin n_err++; $display("FAIL halt_done got=%0h exp=1", done); end
        n_cmp++; if (running !== 1'b0)  begin n_err++; $display("FAIL halt_running got=%0h exp=0", running); end
        n_cmp++; if (status !== 2'b01)  begin n_err++; $display("FAIL halt_status got=%0h exp=1", status); end
        n_cmp++; if (cycle_count !== 13) begin n_err++; $display("FAIL halt_cycle got=%0d exp=13", cycle_count); end
        n_cmp++; if (store_count !== 2)  begin n_err++; $display("FAIL halt_store got=%0d exp=2", store_count); end
        exp_e = sb.pop_front();
        n_cmp++; if ({trace_addr, trace_data} !== exp_e) begin n_err++; $display("FAIL halt_head0 got=%h_%h exp=%h", trace_addr, trace_data, exp_e); end
        trace_rd = 1;
        tick();
        trace_rd = 0;
        exp_e = sb[0];
        n_cmp++; if ({trace_addr, trace_data} !== exp_e) begin n_err++; $display("FAIL halt_head1 got=%h_%h exp=%h", trace_addr, trace_data, exp_e); end
        tick();
        n_cmp++; if (cycle_count !== 13 || status !== 2'b01) begin n_err++; $display("FAIL done_hold got cyc=%0d st=%0h exp cyc=13 st=1", cycle_count, status); end
    endtask

    task automatic test_restart_timeout();
        pc = 32'h200; start = 1;
        tick();
        start = 0;
        sb.delete();
        n_cmp++; if (running !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL restart_flags got run=%0h done=%0h exp 1/0", running, done); end
        n_cmp++; if (status !== 2'b00)  begin n_err++; $display("FAIL restart_status got=%0h exp=0", status); end
        n_cmp++; if (cycle_count !== 0 || store_count !== 0) begin n_err++; $display("FAIL restart_counts got cyc=%0d st=%0d exp 0/0", cycle_count, store_count); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL restart_fifo got=%0h exp=0", trace_valid); end
        for (int i = 0; i < 20; i++) begin
            pc = 32'h200 + 4 * (i + 1);
            start = (i == 5);
            tick();
            if (i == 5) begin
                n_cmp++; if (cycle_count !== 6 || running !== 1'b1) begin n_err++; $display("FAIL start_in_run got cyc=%0d run=%0h exp 6/1", cycle_count, running); end
            end
            if (i == 18) begin
                n_cmp++; if (running !== 1'b1 || cycle_count !== 19) begin n_err++; $display("FAIL tmo_pre got run=%0h cyc=%0d exp 1/19", running, cycle_count); end
            end
        end
        start = 0;
        n_cmp++; if (status !== 2'b10)   begin n_err++; $display("FAIL tmo_status got=%0h exp=2", status); end
        n_cmp++; if (cycle_count !== 20) begin n_err++; $display("FAIL tmo_cycle got=%0d exp=20", cycle_count); end
        n_cmp++; if (running !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL tmo_flags got run=%0h done=%0h exp 0/1", running, done); end
    endtask

    task automatic test_stall(input bit with_halt);
        halt_pc = 32'hFFC; pc = 32'h18; start = 1;
        tick();
        start = 0;
        for (int i = 1; i <= 5; i++) begin
            pc = 32'h1C;
            if (with_halt && i == 5) halt_pc = 32'h1C;
            tick();
            if (i == 4) begin
                n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL stall_pre got run=%0h exp=1", running); end
            end
        end
        n_cmp++; if (status !== (with_halt ? 2'b01 : 2'b11)) begin n_err++; $display("FAIL stall_status got=%0h exp=%0h", status, with_halt ? 2'b01 : 2'b11); end
        n_cmp++; if (cycle_count !== 5 || done !== 1'b1) begin n_err++; $display("FAIL stall_end got cyc=%0d done=%0h exp 5/1", cycle_count, done); end
    endtask

    task automatic test_trace();
        halt_pc = 32'hFFC; pc = 32'h300; start = 1;
        tick();
        start = 0;
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            pc = 32'h300 + 4 * i;
            memWrite = 1;
            aluO = 32'h1000 + 4 * i;
            writeData = $urandom;
            if (sb.size() < 8) sb.push_back({aluO, writeData});
            tick();
            if (i == 7) begin
                n_cmp++; if (trace_ovf !== 1'b0 || trace_valid !== 1'b1) begin n_err++; $display("FAIL trace_fill got ovf=%0h v=%0h exp 0/1", trace_ovf, trace_valid); end
            end
        end
        n_cmp++; if (store_count !== 10) begin n_err++; $display("FAIL trace_store got=%0d exp=10", store_count); end
        n_cmp++; if (trace_ovf !== 1'b1) begin n_err++; $display("FAIL trace_ovf got=%0h exp=1", trace_ovf); end
        // full FIFO, simultaneous push and pop
        pc = 32'h328; memWrite = 1; aluO = 32'h5000; writeData = $urandom; trace_rd = 1;
        exp_e = sb.pop_front();
        n_cmp++; if ({trace_addr, trace_data} !== exp_e) begin n_err++; $display("FAIL pp_head got=%h_%h exp=%h", trace_addr, trace_data, exp_e); end
        sb.push_back({aluO, writeData});
        tick();
        memWrite = 0; trace_rd = 0;
        n_cmp++; if (trace_valid !== 1'b1 || store_count !== 11) begin n_err++; $display("FAIL pp_after got v=%0h st=%0d exp 1/11", trace_valid, store_count); end
        for (int k = 0; k < 8; k++) begin
            pc = 32'h32C + 4 * k;
            if (sb.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL drain_sb got=empty exp=entry");
            end else begin
                exp_e = sb.pop_front();
                n_cmp++; if ({trace_addr, trace_data} !== exp_e) begin n_err++; $display("FAIL drain_%0d got=%h_%h exp=%h", k, trace_addr, trace_data, exp_e); end
            end
            trace_rd = 1;
            tick();
        end
        trace_rd = 0;
        n_cmp++; if (trace_valid !== 1'b0 || running !== 1'b1) begin n_err++; $display("FAIL drain_end got v=%0h run=%0h exp 0/1", trace_valid, running); end
        // empty FIFO push+pop on the timeout cycle: store still lands
        pc = 32'h360; memWrite = 1; aluO = 32'h6000; writeData = $urandom; trace_rd = 1;
        sb.push_back({aluO, writeData});
        tick();
        memWrite = 0; trace_rd = 0;
        n_cmp++; if (status !== 2'b10 || store_count !== 12) begin n_err++; $display("FAIL ep_end got st=%0h sc=%0d exp 2/12", status, store_count); end
        exp_e = sb.pop_front();
        n_cmp++; if (trace_valid !== 1'b1 || {trace_addr, trace_data} !== exp_e) begin n_err++; $display("FAIL ep_head got v=%0h %h_%h exp 1 %h", trace_valid, trace_addr, trace_data, exp_e); end
        trace_rd = 1;
        tick();
        trace_rd = 0;
        n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL done_pop got=%0h exp=0", trace_valid); end
    endtask

    task automatic test_reset_midrun();
        halt_pc = 32'hFFC; pc = 32'h400; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h404 + 4 * i;
            memWrite = (i < 3);
            aluO = 32'h7000 + i;
            writeData = $urandom;
            tick();
        end
        memWrite = 0;
        n_cmp++; if (cycle_count !== 5 || store_count !== 3) begin n_err++; $display("FAIL mid_pre got cyc=%0d st=%0d exp 5/3", cycle_count, store_count); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (running !== 1'b0 || done !== 1'b0 || status !== 2'b00) begin n_err++; $display("FAIL mid_flags got run=%0h done=%0h st=%0h exp 0", running, done, status); end
        n_cmp++; if (cycle_count !== 0 || store_count !== 0) begin n_err++; $display("FAIL mid_counts got cyc=%0d st=%0d exp 0/0", cycle_count, store_count); end
        n_cmp++; if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin n_err++; $display("FAIL mid_fifo got v=%0h ovf=%0h exp 0/0", trace_valid, trace_ovf); end
        n_cmp++; if ({trace_addr, trace_data} !== 64'h0) begin n_err++; $display("FAIL mid_head got=%h_%h exp=0", trace_addr, trace_data); end
        @(negedge clk) rstn = 1'b1;
        sb.delete();
        pc = 32'h500; start = 1;
        tick();
        start = 0;
        n_cmp++; if (running !== 1'b1 || cycle_count !== 0) begin n_err++; $display("FAIL post_start got run=%0h cyc=%0d exp 1/0", running, cycle_count); end
        pc = 32'h504;
        tick();
        n_cmp++; if (cycle_count !== 1) begin n_err++; $display("FAIL post_cycle got=%0d exp=1", cycle_count); end
        halt_pc = 32'h508; pc = 32'h508;
        tick();
        n_cmp++; if (status !== 2'b01 || done !== 1'b1 || cycle_count !== 2) begin n_err++; $display("FAIL post_halt got st=%0h done=%0h cyc=%0d exp 1/1/2", status, done, cycle_count); end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_restart_timeout();
        test_stall(1'b0);
        test_stall(1'b1);
        test_trace();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
